// File: rtl/div_iter_ex.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_iter_ex : iterative radix-2 restoring divider for DIV/DIVU in EX.    |
// | Optional macro DIV_EARLY_TERM_EN: finish at once when |divisor|>|divd|.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module div_iter_ex #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  input  logic             accept,
  output logic             div_stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int              CW     = $clog2(WIDTH + 1);
  localparam logic [1:0]      S_IDLE = 2'd0;
  localparam logic [1:0]      S_BUSY = 2'd1;
  localparam logic [1:0]      S_DONE = 2'd2;
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             early_exit;

  assign abs_a = (signed_div & opa[WIDTH-1]) ? (C_ZERO - opa) : opa;
  assign abs_b = (signed_div & opb[WIDTH-1]) ? (C_ZERO - opb) : opb;

`ifdef DIV_EARLY_TERM_EN
  assign early_exit = (abs_b > abs_a);
`else
  assign early_exit = 1'b0;
`endif

  // Dividend bits are shifted out of the quotient register's MSB as quotient
  // bits enter at its LSB; the trial value needs one extra bit of headroom.
  assign trial    = {rem_q, quo_q[WIDTH-1]};
  assign trial_ge = (trial >= {1'b0, dvs_q});
  assign rem_step = trial_ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], trial_ge};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ready_d = ready_q;
    if (cancel) begin
      state_d = S_IDLE;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_d   = '0;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            qsign_d = (opa[WIDTH-1] ^ opb[WIDTH-1]) & signed_div;
            rsign_d = opa[WIDTH-1] & signed_div;
            count_d = '0;
            if (opb == C_ZERO) begin
              state_d = S_DONE;
              ready_d = 1'b1;
              lo_d    = '1;
              hi_d    = opa;
            end else if (early_exit) begin
              state_d = S_DONE;
              ready_d = 1'b1;
              lo_d    = '0;
              hi_d    = opa;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_d   = rem_step;
          quo_d   = quo_step;
          count_d = count_q + CW'(1);
          if (count_q == C_LAST) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            hi_d    = rsign_q ? (C_ZERO - rem_step) : rem_step;
            lo_d    = qsign_q ? (C_ZERO - quo_step) : quo_step;
          end
        end
        S_DONE: begin
          if (accept) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ready_q <= ready_d;
    end
  end

  // Dropping the stall in DONE lets the divide instruction leave EX.
  assign div_stall = start & ~cancel & (state_q != S_DONE);
  assign ready     = ready_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_ex.sv
`default_nettype none
// tb_div_iter_ex: table + scoreboard bench for the iterative divider.
module tb_div_iter_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_div, cancel, accept;
  logic [31:0] opa, opb;
  logic        div_stall, ready;
  logic [31:0] hi_out, lo_out;

  always #5 clk = ~clk;

  div_iter_ex #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .cancel     (cancel),
    .accept     (accept),
    .div_stall  (div_stall),
    .ready      (ready),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } exp_t;

  vec_t        tbl[10];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_lo, last_hi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_TERM_EN
    if (mb > ma) return 1;
`endif
    return 33;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.lat = exp_lat(a, b, s);
    if (b == 32'd0) begin
      e.lo = '1; e.hi = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000; e.hi = 32'd0;
    end else if (s) begin
      e.lo = $signed(a) / $signed(b);
      e.hi = $signed(a) % $signed(b);
    end else begin
      e.lo = a / b; e.hi = a % b;
    end
    return e;
  endfunction

  // One complete operation: start, wait for ready, optional hold, accept.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] elo, input logic [31:0] ehi, input int hold);
    exp_t e;
    int   cyc;
    bit   seen;
    @(posedge clk); #1;
    opa = a; opb = b; signed_div = s; start = 1'b1; accept = (hold == 0);
    e.lo = elo; e.hi = ehi; e.lat = exp_lat(a, b, s);
    sb.push_back(e);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
      else begin
        chk("stall_while_busy", {31'd0, div_stall}, 32'd1);
        cyc++;
        @(posedge clk); #1;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL timeout: ready not seen, waited %0d cycles, required latency %0d", cyc, e.lat);
      start = 1'b0; cancel = 1'b1;
      @(posedge clk); #1; cancel = 1'b0;
    end else begin
      chk("latency", cyc, e.lat);
      chk("stall_in_done", {31'd0, div_stall}, 32'd0);
      chk("lo_out", lo_out, e.lo);
      chk("hi_out", hi_out, e.hi);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_ready", {31'd0, ready}, 32'd1);
        chk("hold_lo", lo_out, e.lo);
        chk("hold_hi", hi_out, e.hi);
      end
      if (hold > 0) begin
        @(posedge clk); #1; accept = 1'b1;
        @(negedge clk);
        chk("ready_in_accept_cycle", {31'd0, ready}, 32'd1);
      end
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("ready_drop", {31'd0, ready}, 32'd0);
      chk("stall_idle", {31'd0, div_stall}, 32'd0);
      chk("lo_keep", lo_out, e.lo);
      chk("hi_keep", hi_out, e.hi);
    end
    last_lo = elo;
    last_hi = ehi;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    logic [31:0] ra, rb;
    logic        rs;
    bit          bad;

    tbl[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678};
    tbl[3] = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3};
    tbl[4] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    tbl[5] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    tbl[6] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE};
    tbl[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
    tbl[8] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0};
    tbl[9] = '{32'hFFFF_FFFF,  32'h0000_FFFF,  1'b0, 32'h0001_0001,  32'd0};

    rst = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; accept = 1'b0;
    opa = '0; opb = '0;
    @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_lo", lo_out, 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_stall", {31'd0, div_stall}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].lo, tbl[i].hi, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rs);
      do_op(ra, rb, rs, m.lo, m.hi, 0);
    end

    // Signed overflow with the EX stage held for five cycles.
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 5);

    // Cancel in BUSY at T+10, restart at T+12.
    @(posedge clk); #1;
    opa = 32'd5000; opb = 32'd3; signed_div = 1'b0; start = 1'b1; accept = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (ready) bad = 1'b1;
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    @(negedge clk);
    chk("stall_on_cancel", {31'd0, div_stall}, 32'd0);
    @(posedge clk); #1; cancel = 1'b0; start = 1'b0;
    @(negedge clk);
    if (ready) bad = 1'b1;
    chk("cancel_no_ready", {31'd0, bad}, 32'd0);
    chk("cancel_lo_keep", lo_out, last_lo);
    chk("cancel_hi_keep", hi_out, last_hi);
    do_op(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 0);

    // Cancel beats start in IDLE: no operation must ever complete.
    @(posedge clk); #1;
    opa = 32'd77; opb = 32'd5; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    chk("idle_cancel_stall", {31'd0, div_stall}, 32'd0);
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    bad = 1'b0;
    repeat (36) begin @(negedge clk); if (ready) bad = 1'b1; end
    chk("idle_cancel_no_op", {31'd0, bad}, 32'd0);
    chk("idle_cancel_lo_keep", lo_out, last_lo);

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    opa = 32'd999; opb = 32'd4; signed_div = 1'b0; start = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, ready}, 32'd0);
    chk("async_rst_lo", lo_out, 32'd0);
    chk("async_rst_hi", hi_out, 32'd0);
    start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    bad = 1'b0;
    repeat (36) begin @(negedge clk); if (ready) bad = 1'b1; end
    chk("rst_no_resume", {31'd0, bad}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_iter_ex.md
Name: div_iter_ex

Overview:
- Iterative 32-bit radix-2 restoring divider in the execute stage, directly downstream of the ID/EX pipeline register.
- Serves DIV/DIVU: consumes rd1E/rd2E-derived operands and the decoded divide request.
- Stalls the pipeline while busy and delivers {HI=remainder, LO=quotient} for the HI/LO write path.
- Flushes and exceptions cancel it cleanly.

Parameters:
- WIDTH, 32, operand width. Quotient and remainder are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- start  in  1  divide requested by the instruction in EX; held high by the pipeline while stalled
- signed_div  in  1  1=DIV, 0=DIVU; sampled with start in IDLE
- opa  in  WIDTH  dividend (forwarded rs value)
- opb  in  WIDTH  divisor (forwarded rt value)
- cancel  in  1  flushE or exception flush; aborts the operation
- accept  in  1  EX stage advancing this cycle (~stallE)
- div_stall  out  1  stall request to the hazard unit
- ready  out  1  result valid
- hi_out  out  WIDTH  remainder
- lo_out  out  WIDTH  quotient

Behaviour:
- States: IDLE, BUSY, DONE. Reset (rst=0, asynchronous): state=IDLE, count=0, hi_out=0, lo_out=0, ready=0, internal partial-remainder and quotient registers=0.
- IDLE:
  - start=1 and cancel=0: latch |opa| and |opb|. Magnitudes are used only when signed_div=1; otherwise raw values.
  - Also latch the quotient sign (opa[31]^opb[31])&signed_div and the remainder sign opa[31]&signed_div.
  - opb==0: go to DONE next cycle with lo_out=all ones, hi_out=opa.
  - Otherwise go to BUSY with count=0.
- BUSY: one quotient bit per cycle.
  - Partial remainder shifts left, taking the next dividend MSB.
  - If it is >= divisor: subtract, quotient bit=1.
  - count increments. After the 32nd BUSY cycle, go to DONE.
  - On the transition, write sign-corrected results into hi_out/lo_out (two's-complement negation where the sign bit is set).
- Latency: start sampled at cycle T; BUSY occupies T+1..T+32; DONE, with ready=1, from T+33.
- DONE:
  - ready=1; hi_out/lo_out stable.
  - Stay in DONE while accept=0.
  - accept=1: go to IDLE next cycle. ready drops then, and results hold their values until the next completion.
- div_stall = start & ~cancel & (state!=DONE), combinational. It is therefore 0 in the DONE cycle, letting the instruction leave EX.
- cancel=1 in any state: IDLE next cycle, ready=0, hi_out/lo_out not updated. cancel has priority over start and accept in the same cycle.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0. This falls out of the magnitude arithmetic; no trap.
- start asserted while BUSY or DONE is ignored; operands are not re-sampled.
- Reset mid-operation returns immediately to the reset values above.

Optional Feature:
- Macro DIV_EARLY_TERM_EN.
- Defined: in IDLE, if the divisor magnitude exceeds the dividend magnitude (opb!=0), go straight to DONE next cycle with lo_out=0 and hi_out=opa. Latency is 1 cycle; ready at T+1.
- Undefined: every nonzero-divisor operation takes the full 32 BUSY cycles; only divide-by-zero short-circuits.

Test Plan:
- DIVU: opa=100, opb=7, start at T, accept=1 -> div_stall=1 for T..T+32; ready=1 at T+33; lo_out=14, hi_out=2; IDLE at T+34.
- DIV: opa=0xFFFFFFF9 (-7), opb=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1) at T+33.
- Divide by zero: opa=0x12345678, opb=0 -> ready at T+1; lo_out=0xFFFFFFFF, hi_out=0x12345678.
- Cancel: start at T, cancel=1 at T+10 -> IDLE at T+11, ready never asserts, hi_out/lo_out unchanged from the previous result; a new start at T+12 completes normally at T+45.
- Hold: DIV 0x80000000 / 0xFFFFFFFF with accept=0 for 5 cycles after ready -> ready stays 1 with lo_out=0x80000000, hi_out=0; ready drops the cycle after accept=1.
- Early-exit: with DIV_EARLY_TERM_EN defined, DIVU 3/10 -> ready at T+1, lo_out=0, hi_out=3. Without the macro, the same result arrives at T+33.
